// File: rtl/player_frame_controller.sv
// Frame-rate sequencer: samples buttons on frame_end, runs the title/play/pause/over
// state machine, and issues move/attack strobes with sword and cooldown timing.
module player_frame_controller #(
    parameter int MOVE_DIV        = 4,
    parameter int ATTACK_FRAMES   = 8,
    parameter int COOLDOWN_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       A,
    input  logic       B,
    input  logic       start,
    input  logic       select,
    input  logic [1:0] player_health,
    output logic [1:0] game_state,
    output logic       move_tick,
    output logic [3:0] move_dir,
    output logic [3:0] facing,
    output logic       attack_start,
    output logic       sword_active,
    output logic [3:0] sword_dir
);
    typedef enum logic [1:0] {
        ST_TITLE = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_DIV - 1);
    localparam logic [4:0] ATK_LEN = 5'(ATTACK_FRAMES);
    localparam logic [4:0] CD_LEN  = 5'(COOLDOWN_FRAMES);

    state_t        state_q, state_d;
    logic [MW-1:0] move_cnt_q, move_cnt_d;
    logic [4:0]    atk_cnt_q, atk_cnt_d;
    logic [4:0]    cd_cnt_q, cd_cnt_d;
    logic          prev_start_q, prev_start_d;
    logic          prev_select_q, prev_select_d;
    logic          prev_atk_q, prev_atk_d;
    logic          move_tick_q, move_tick_d;
    logic [3:0]    move_dir_q, move_dir_d;
    logic [3:0]    facing_q, facing_d;
    logic          attack_start_q, attack_start_d;
    logic          sword_active_q, sword_active_d;
    logic [3:0]    sword_dir_q, sword_dir_d;

    logic       start_edge, select_edge, atk_edge;
    logic [3:0] dir_now;

    // Opposing buttons cancel their axis; survivors resolve up > down > left > right.
    function automatic logic [3:0] decode_dir(input logic u, input logic d,
                                              input logic l, input logic r);
        logic [3:0] res;
        res = 4'b0000;
        if (u && !d)      res = 4'b1000;
        else if (d && !u) res = 4'b0100;
        else if (l && !r) res = 4'b0010;
        else if (r && !l) res = 4'b0001;
        return res;
    endfunction

    assign dir_now     = decode_dir(up, down, left, right);
    assign start_edge  = start & ~prev_start_q;
    assign select_edge = select & ~prev_select_q;
    assign atk_edge    = (A | B) & ~prev_atk_q;

    always_comb begin
        state_d        = state_q;
        move_cnt_d     = move_cnt_q;
        atk_cnt_d      = atk_cnt_q;
        cd_cnt_d       = cd_cnt_q;
        prev_start_d   = prev_start_q;
        prev_select_d  = prev_select_q;
        prev_atk_d     = prev_atk_q;
        move_tick_d    = 1'b0;
        move_dir_d     = move_dir_q;
        facing_d       = facing_q;
        attack_start_d = 1'b0;
        sword_active_d = sword_active_q;
        sword_dir_d    = sword_dir_q;

        if (frame_end) begin
            prev_start_d  = start;
            prev_select_d = select;
            prev_atk_d    = A | B;
            move_dir_d    = dir_now;
            if (dir_now != 4'b0000) facing_d = dir_now;

            unique case (state_q)
                ST_TITLE: begin
                    if (start_edge) begin
                        state_d        = ST_PLAY;
                        move_cnt_d     = '0;
                        atk_cnt_d      = '0;
                        cd_cnt_d       = '0;
                        sword_active_d = 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (player_health == 2'b00) begin
                        state_d        = ST_OVER;
                        move_cnt_d     = '0;
                        atk_cnt_d      = '0;
                        cd_cnt_d       = '0;
                        sword_active_d = 1'b0;
                    end else if (start_edge) begin
                        state_d = ST_PAUSE;
                    end else begin
                        if (move_cnt_q == MOVE_LAST) begin
                            move_cnt_d  = '0;
                            move_tick_d = (dir_now != 4'b0000);
                        end else begin
                            move_cnt_d = move_cnt_q + MW'(1);
                        end
                        // Sword window, then cooldown; edges arriving in either are dropped.
                        if (sword_active_q) begin
                            if (atk_cnt_q <= 5'd1) begin
                                sword_active_d = 1'b0;
                                atk_cnt_d      = '0;
                                cd_cnt_d       = CD_LEN;
                            end else begin
                                atk_cnt_d = atk_cnt_q - 5'd1;
                            end
                        end else if (cd_cnt_q != 5'd0) begin
                            cd_cnt_d = cd_cnt_q - 5'd1;
                        end else if (atk_edge) begin
                            attack_start_d = 1'b1;
                            sword_active_d = 1'b1;
                            atk_cnt_d      = ATK_LEN;
                            sword_dir_d    = facing_d;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (select_edge) begin
                        state_d        = ST_TITLE;
                        move_cnt_d     = '0;
                        atk_cnt_d      = '0;
                        cd_cnt_d       = '0;
                        sword_active_d = 1'b0;
                    end else if (start_edge) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_OVER: begin
                    if (start_edge) begin
                        state_d        = ST_TITLE;
                        move_cnt_d     = '0;
                        atk_cnt_d      = '0;
                        cd_cnt_d       = '0;
                        sword_active_d = 1'b0;
                    end
                end
                default: state_d = ST_TITLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_TITLE;
            move_cnt_q     <= '0;
            atk_cnt_q      <= '0;
            cd_cnt_q       <= '0;
            prev_start_q   <= 1'b0;
            prev_select_q  <= 1'b0;
            prev_atk_q     <= 1'b0;
            move_tick_q    <= 1'b0;
            move_dir_q     <= 4'b0000;
            facing_q       <= 4'b0100;
            attack_start_q <= 1'b0;
            sword_active_q <= 1'b0;
            sword_dir_q    <= 4'b0100;
        end else begin
            state_q        <= state_d;
            move_cnt_q     <= move_cnt_d;
            atk_cnt_q      <= atk_cnt_d;
            cd_cnt_q       <= cd_cnt_d;
            prev_start_q   <= prev_start_d;
            prev_select_q  <= prev_select_d;
            prev_atk_q     <= prev_atk_d;
            move_tick_q    <= move_tick_d;
            move_dir_q     <= move_dir_d;
            facing_q       <= facing_d;
            attack_start_q <= attack_start_d;
            sword_active_q <= sword_active_d;
            sword_dir_q    <= sword_dir_d;
        end
    end

    assign game_state   = state_q;
    assign move_tick    = move_tick_q;
    assign move_dir     = move_dir_q;
    assign facing       = facing_q;
    assign attack_start = attack_start_q;
    assign sword_active = sword_active_q;
    assign sword_dir    = sword_dir_q;
endmodule

// File: tb/tb_player_frame_controller.sv
// Scoreboard bench for player_frame_controller: a frame-level reference model predicts
// each post-frame output vector; a monitor pops and compares when the DUT updates.
module tb_player_frame_controller;
    localparam int MOVE_DIV = 4;
    localparam int AF       = 8;
    localparam int CF       = 16;

    localparam logic [7:0] BU = 8'h80, BD = 8'h40, BL = 8'h20, BR = 8'h10;
    localparam logic [7:0] BA = 8'h08, BB = 8'h04, BST = 8'h02, BSE = 8'h01;
    localparam logic [16:0] RESET_VEC = {2'b00, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 4'b0100};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_end = 1'b0;
    logic up = 0, down = 0, left = 0, right = 0, A = 0, B = 0, start = 0, select = 0;
    logic [1:0] player_health = 2'd3;
    logic [1:0] game_state;
    logic move_tick, attack_start, sword_active;
    logic [3:0] move_dir, facing, sword_dir;

    player_frame_controller #(
        .MOVE_DIV(MOVE_DIV), .ATTACK_FRAMES(AF), .COOLDOWN_FRAMES(CF)
    ) dut (
        .clk(clk), .reset(reset), .frame_end(frame_end),
        .up(up), .down(down), .left(left), .right(right),
        .A(A), .B(B), .start(start), .select(select),
        .player_health(player_health),
        .game_state(game_state), .move_tick(move_tick), .move_dir(move_dir),
        .facing(facing), .attack_start(attack_start), .sword_active(sword_active),
        .sword_dir(sword_dir)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;
    logic [16:0] exp_q[$];
    logic fe_seen;
    logic [16:0] dut_vec;

    assign dut_vec = {game_state, move_tick, move_dir, facing, attack_start, sword_active, sword_dir};

    // Reference model state: game mode, PLAY frames since entering, frames since attack began.
    int   m_state;
    int   m_play_frames;
    int   m_since;
    bit   m_ps, m_psel, m_pab;
    logic [3:0] m_dir, m_facing, m_swdir;

    task automatic model_reset();
        m_state = 0; m_play_frames = 0; m_since = -1;
        m_ps = 0; m_psel = 0; m_pab = 0;
        m_dir = 4'b0000; m_facing = 4'b0100; m_swdir = 4'b0100;
    endtask

    function automatic logic [3:0] model_dir(input logic [7:0] btn);
        int v, h;
        v = int'(btn[6]) - int'(btn[7]);
        h = int'(btn[4]) - int'(btn[5]);
        if (v == -1) return 4'b1000;
        if (v == 1)  return 4'b0100;
        if (h == -1) return 4'b0010;
        if (h == 1)  return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [16:0] model_frame(input logic [7:0] btn, input logic [1:0] hp);
        bit se, sl, ae, tick, atk, sword;
        logic [3:0] d;
        d  = model_dir(btn);
        se = btn[1] && !m_ps;
        sl = btn[0] && !m_psel;
        ae = (btn[3] || btn[2]) && !m_pab;
        m_ps = btn[1]; m_psel = btn[0]; m_pab = btn[3] || btn[2];
        tick = 0; atk = 0;
        m_dir = d;
        if (d != 0) m_facing = d;
        case (m_state)
            0: if (se) begin m_state = 1; m_play_frames = 0; m_since = -1; end
            1: begin
                if (hp == 0) begin
                    m_state = 3; m_play_frames = 0; m_since = -1;
                end else if (se) begin
                    m_state = 2;
                end else begin
                    m_play_frames++;
                    if ((m_play_frames % MOVE_DIV) == 0 && d != 0) tick = 1;
                    if (m_since >= 0) m_since++;
                    if (ae && (m_since < 0 || m_since > AF + CF)) begin
                        m_since = 0; atk = 1; m_swdir = m_facing;
                    end
                end
            end
            2: begin
                if (sl) begin m_state = 0; m_play_frames = 0; m_since = -1; end
                else if (se) m_state = 1;
            end
            default: if (se) begin m_state = 0; m_play_frames = 0; m_since = -1; end
        endcase
        sword = (m_since >= 0) && (m_since < AF);
        return {2'(m_state), tick, m_dir, m_facing, atk, sword, m_swdir};
    endfunction

    task automatic drive_btn(input logic [7:0] btn);
        {up, down, left, right, A, B, start, select} = btn;
    endtask

    task automatic do_frame(input logic [7:0] btn, input logic [1:0] hp, input int gap);
        @(negedge clk);
        drive_btn(btn);
        player_health = hp;
        frame_end = 1'b1;
        exp_q.push_back(model_frame(btn, hp));
        @(negedge clk);
        frame_end = 1'b0;
        for (int g = 0; g < gap; g++) begin
            drive_btn(8'($urandom));
            player_health = 2'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic f(input logic [7:0] btn, input logic [1:0] hp);
        do_frame(btn, hp, 2);
    endtask

    task automatic pulse_reset_check(input string name);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b", name, dut_vec, RESET_VEC);
        end
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) fe_seen <= 1'b0;
        else       fe_seen <= frame_end;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (fe_seen) begin
                frame_no++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_out #%0d: actual=%b required=<no entry>", frame_no, dut_vec);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    if (dut_vec !== e) begin
                        errors++;
                        $display("FAIL frame_out #%0d: actual=%b required=%b (state,tick,dir,facing,atk,sword,swdir)",
                                 frame_no, dut_vec, e);
                    end
                end
            end else begin
                checks++;
                if (move_tick !== 1'b0 || attack_start !== 1'b0) begin
                    errors++;
                    $display("FAIL strobe_idle: actual tick=%b atk=%b required 0 0", move_tick, attack_start);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_state: actual=%b required=%b", dut_vec, RESET_VEC);
        end

        // Start held across several frames gives exactly one transition.
        repeat (3) f(BST, 2'd3);
        // Movement cadence, then cancelled vertical axis.
        repeat (8) f(BU, 2'd3);
        repeat (2) f(BU | BD, 2'd3);
        // Face right, then attack / cooldown rejection / acceptance.
        f(BR, 2'd3);
        for (int i = 0; i < 30; i++)
            f((i == 0 || i == 12 || i == 25) ? BA : 8'h00, 2'd3);
        // Pause mid-sword, hold for 10 frames, resume.
        f(BST, 2'd3);
        for (int i = 0; i < 10; i++) f((i % 2 == 0) ? (BL | BB) : BU, 2'd3);
        f(BST, 2'd3);
        repeat (6) f(8'h00, 2'd3);
        // Health zero beats start; then start returns to title.
        f(8'h00, 2'd3);
        f(BST, 2'd0);
        f(8'h00, 2'd0);
        f(BST, 2'd1);
        // Pause with start and select edges together goes to title.
        f(8'h00, 2'd3);
        f(BST, 2'd3);
        f(8'h00, 2'd3);
        f(BST, 2'd3);
        f(8'h00, 2'd3);
        f(BST | BSE, 2'd3);
        // Back to play, attack, then asynchronous reset mid-attack.
        f(8'h00, 2'd3);
        f(BST, 2'd3);
        f(BL, 2'd3);
        f(BB, 2'd3);
        f(8'h00, 2'd3);
        pulse_reset_check("reset_mid_attack");

        for (int n = 0; n < 800; n++) begin
            logic [7:0] btn;
            logic [1:0] hp;
            btn[7] = ($urandom_range(0, 9) < 4);
            btn[6] = ($urandom_range(0, 9) < 4);
            btn[5] = ($urandom_range(0, 9) < 4);
            btn[4] = ($urandom_range(0, 9) < 4);
            btn[3] = ($urandom_range(0, 9) < 3);
            btn[2] = ($urandom_range(0, 9) < 2);
            btn[1] = ($urandom_range(0, 9) < 1);
            btn[0] = ($urandom_range(0, 9) < 1);
            hp = ($urandom_range(0, 39) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            do_frame(btn, hp, $urandom_range(1, 3));
            if (n == 400) pulse_reset_check("reset_random");
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
